// File: rtl/seg_display_engine.sv
// Time-multiplexed N-digit seven-segment engine: prescaler, scan counter, hex decode,
// per-digit blank/dp, PWM brightness, and a double-buffered frame swapped at scan wrap.
module seg_display_engine #(
   parameter int NUM_DIGITS = 4,
   parameter int DIVIDE_BY  = 17,
   parameter int BRIGHT_W   = 2,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [BRIGHT_W-1:0]     brightness,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    frame_done
);
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic OFF = (ACTIVE_LOW != 0);

   logic [DIVIDE_BY-1:0]    presc;
   logic [IDX_W-1:0]        idx;
   logic                    pending, pending_nxt;
   logic [4*NUM_DIGITS-1:0] sh_digits, act_digits;
   logic [NUM_DIGITS-1:0]   sh_blank, act_blank;
   logic [NUM_DIGITS-1:0]   sh_dp, act_dp;

   logic                    tick, wrap, xfer, lit, show;
   logic [BRIGHT_W-1:0]     top;
   logic [NUM_DIGITS-1:0]   sel;
   logic [3:0]              cur_nib;
   logic                    cur_blank, cur_dp;
   logic [NUM_DIGITS-1:0]   an_l;
   logic [6:0]              seg_l;
   logic                    dp_l;

   // Active-low patterns, bit 6 = g ... bit 0 = a
   function automatic logic [6:0] hex_seg(input logic [3:0] h);
      logic [6:0] s;
      s = 7'h7F;
      case (h)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         4'hF: s = 7'b0001110;
      endcase
      return s;
   endfunction

   always_comb begin
      tick = &presc;
      wrap = tick && (idx == LAST_IDX);
      xfer = load_valid && load_ready;
      // A transfer can only happen while nothing is pending, so it never collides with a swap
      pending_nxt = xfer ? 1'b1 : (wrap ? 1'b0 : pending);

      top = presc[DIVIDE_BY-1 -: BRIGHT_W];
      lit = (top < brightness) || (&brightness);

      sel       = '0;
      cur_nib   = '0;
      cur_blank = 1'b1;
      cur_dp    = 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            sel[i]    = 1'b1;
            cur_nib   = act_digits[4*i +: 4];
            cur_blank = act_blank[i];
            cur_dp    = act_dp[i];
         end
      end

      show  = lit && !cur_blank;
      an_l  = ~(sel & {NUM_DIGITS{show}});
      seg_l = show ? hex_seg(cur_nib) : 7'h7F;
      dp_l  = ~(show && cur_dp);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         presc      <= '0;
         idx        <= '0;
         pending    <= 1'b0;
         load_ready <= 1'b0;
         act_digits <= '0;
         act_blank  <= '1;
         act_dp     <= '0;
         frame_done <= 1'b0;
         an         <= {NUM_DIGITS{OFF}};
         seg        <= {7{OFF}};
         dp         <= OFF;
      end else begin
         presc <= presc + 1'b1;
         if (tick) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
         end
         pending    <= pending_nxt;
         load_ready <= ~pending_nxt;
         frame_done <= wrap;
         if (wrap && pending) begin
            act_digits <= sh_digits;
            act_blank  <= sh_blank;
            act_dp     <= sh_dp;
         end
         an  <= OFF ? an_l  : ~an_l;
         seg <= OFF ? seg_l : ~seg_l;
         dp  <= OFF ? dp_l  : ~dp_l;
      end
   end

   // Shadow contents are meaningless unless pending is set, so they need no reset
   always_ff @(posedge clk) begin
      if (xfer) begin
         sh_digits <= digits_in;
         sh_blank  <= blank_in;
         sh_dp     <= dp_in;
      end
   end
endmodule

// File: tb/tb_seg_display_engine.sv
// Bench for seg_display_engine: time-based frame model compared every cycle, plus
// directed literal checks on reset, handshake, swap timing, blanking and brightness.
module tb_seg_display_engine;
   logic        clk;
   logic        reset;
   logic [15:0] digits_in;
   logic [3:0]  blank_in;
   logic [3:0]  dp_in;
   logic        load_valid;
   logic        load_ready;
   logic [1:0]  brightness;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   seg_display_engine #(
      .NUM_DIGITS(4),
      .DIVIDE_BY(4),
      .BRIGHT_W(2),
      .ACTIVE_LOW(1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .digits_in(digits_in),
      .blank_in(blank_in),
      .dp_in(dp_in),
      .load_valid(load_valid),
      .load_ready(load_ready),
      .brightness(brightness),
      .an(an),
      .seg(seg),
      .dp(dp),
      .frame_done(frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: everything is a function of t, the number of running edges since reset
   logic [6:0] hex_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   int          t;
   bit          model_ok = 0;
   bit          m_pend;
   logic [15:0] m_sh_d, m_act_d;
   logic [3:0]  m_sh_b, m_act_b, m_sh_p, m_act_p;
   logic [3:0]  exp_an;
   logic [6:0]  exp_seg;
   logic        exp_dp, exp_fd, exp_rdy;

   initial begin
      forever begin
         int  slot, phase;
         bit  on;
         @(posedge clk);
         if (!reset) begin
            t = 0;
            m_pend  = 0;
            m_act_d = 16'h0;
            m_act_b = 4'hF;
            m_act_p = 4'h0;
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
            exp_fd  = 1'b0;
            exp_rdy = 1'b0;
         end else begin
            slot  = (t / 16) % 4;
            phase = t % 16;
            on = ((brightness == 2'd3) || ((phase / 4) < int'(brightness))) && !m_act_b[slot];
            exp_an  = on ? ~(4'b0001 << slot) : 4'hF;
            exp_seg = on ? hex_tab[m_act_d[slot*4 +: 4]] : 7'h7F;
            exp_dp  = on ? ~m_act_p[slot] : 1'b1;
            exp_fd  = ((t % 64) == 63);
            if (exp_fd && m_pend) begin
               m_act_d = m_sh_d;
               m_act_b = m_sh_b;
               m_act_p = m_sh_p;
               m_pend  = 0;
            end
            if (load_valid && !m_pend) begin
               m_sh_d = digits_in;
               m_sh_b = blank_in;
               m_sh_p = dp_in;
               m_pend = 1;
            end
            exp_rdy = !m_pend;
            t++;
         end
         model_ok = 1;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (model_ok) begin
            chk("an", an, exp_an);
            chk("seg", seg, exp_seg);
            chk("dp", dp, exp_dp);
            chk("frame_done", frame_done, exp_fd);
            chk("load_ready", load_ready, exp_rdy);
         end
      end
   end

   task automatic wait_t(input int k);
      int n = 0;
      while (t != k && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (t != k) begin
         checks++;
         errors++;
         $display("FAIL wait_t: reached t=%0d expected t=%0d", t, k);
      end
   endtask

   initial begin
      int cnt;
      reset = 1'b0;
      load_valid = 1'b0;
      brightness = 2'd3;
      digits_in = 16'h0;
      blank_in = 4'h0;
      dp_in = 4'h0;

      repeat (3) @(negedge clk);
      chk("rst_an", an, 4'hF);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_dp", dp, 1'b1);
      chk("rst_rdy", load_ready, 1'b0);
      chk("rst_fd", frame_done, 1'b0);
      reset = 1'b1;

      @(negedge clk);
      chk("rdy_after_rst", load_ready, 1'b1);
      cnt = 0;
      repeat (63) begin
         @(negedge clk);
         if (an != 4'hF) cnt++;
      end
      chk("dark_frame", cnt, 0);

      wait_t(64);
      digits_in = 16'h1A2F;
      blank_in = 4'h0;
      dp_in = 4'b0100;
      load_valid = 1'b1;
      @(negedge clk);
      chk("rdy_fall", load_ready, 1'b0);
      digits_in = 16'h5555;
      dp_in = 4'b1111;
      wait_t(120);
      load_valid = 1'b0;
      wait_t(127);
      chk("dark_before_wrap", an, 4'hF);
      wait_t(128);
      chk("fd_wrap1", frame_done, 1'b1);
      chk("rdy_wrap1", load_ready, 1'b1);
      wait_t(129);
      chk("s0_an", an, 4'b1110);
      chk("s0_seg", seg, 7'b0001110);
      chk("s0_dp", dp, 1'b1);
      wait_t(145);
      chk("s1_an", an, 4'b1101);
      chk("s1_seg", seg, 7'b0100100);
      wait_t(161);
      chk("s2_an", an, 4'b1011);
      chk("s2_seg", seg, 7'b0001000);
      chk("s2_dp", dp, 1'b0);
      wait_t(177);
      chk("s3_an", an, 4'b0111);
      chk("s3_seg", seg, 7'b1111001);

      wait_t(191);
      digits_in = 16'h3456;
      blank_in = 4'h0;
      dp_in = 4'h0;
      load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      chk("wrapload_rdy", load_ready, 1'b0);
      chk("wrapload_fd", frame_done, 1'b1);
      wait_t(193);
      chk("wrapload_old_seg", seg, 7'b0001110);
      wait_t(257);
      chk("wrapload_new_an", an, 4'b1110);
      chk("wrapload_new_seg", seg, 7'b0000010);
      chk("wrapload_rdy2", load_ready, 1'b1);

      wait_t(260);
      blank_in = 4'b0010;
      load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      wait_t(324);
      chk("blank_s0_seg", seg, 7'b0000010);
      wait_t(340);
      chk("blank_s1_an", an, 4'hF);
      chk("blank_s1_seg", seg, 7'h7F);
      wait_t(356);
      chk("blank_s2_an", an, 4'b1011);
      chk("blank_s2_seg", seg, 7'b0011001);

      wait_t(384);
      brightness = 2'd1;
      cnt = 0;
      repeat (16) begin
         @(negedge clk);
         if (an != 4'hF) cnt++;
      end
      chk("bright1_on_cycles", cnt, 4);
      brightness = 2'd0;
      cnt = 0;
      repeat (64) begin
         @(negedge clk);
         if (an != 4'hF) cnt++;
      end
      chk("bright0_on_cycles", cnt, 0);
      brightness = 2'd3;

      wait_t(470);
      digits_in = 16'h8888;
      blank_in = 4'h0;
      load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rerst_rdy", load_ready, 1'b1);
      cnt = 0;
      repeat (70) begin
         @(negedge clk);
         if (an != 4'hF) cnt++;
      end
      chk("rerst_dark", cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/seg_display_engine.md
Name: seg_display_engine

Overview:
- Parametrised N-digit, time-multiplexed seven-segment display engine. It is the next-generation replacement for the separate clock-divider, scanner and decoder chain under the board top level.
- Combines a prescaler, digit scan counter, hex decoder, per-digit blank and decimal point, and PWM brightness.
- Digit data is double-buffered: a valid/ready load handshake writes a shadow frame, which is swapped in only at a scan-frame boundary, so the display never tears.

Parameters:
- NUM_DIGITS, 4: digits scanned; also the width of the per-digit buses. Range 2..8.
- DIVIDE_BY, 17: prescaler width. One scan slot lasts 2^DIVIDE_BY clk cycles.
- BRIGHT_W, 2: brightness input width. Requires BRIGHT_W <= DIVIDE_BY.
- ACTIVE_LOW, 1: 1 means an, seg and dp are driven active-low. 0 means active-high.

Ports:
- clk, input, 1: board clock; single clock domain.
- reset, input, 1: synchronous, active-low reset.
- digits_in, input, 4*NUM_DIGITS: hex nibble per digit; digit i is bits [4i+3:4i]; digit 0 is rightmost.
- blank_in, input, NUM_DIGITS: 1 means digit i is dark.
- dp_in, input, NUM_DIGITS: 1 means digit i lights its decimal point.
- load_valid, input, 1: producer offers a new frame.
- load_ready, output, 1: engine can accept a frame.
- brightness, input, BRIGHT_W: duty-cycle level.
- an, output, NUM_DIGITS: digit anodes.
- seg, output, 7: segments; seg[0]=a ... seg[6]=g.
- dp, output, 1: decimal point.
- frame_done, output, 1: one-cycle pulse at every scan wrap.

Behaviour:
- Reset is sampled at a clk edge with reset==0. It sets:
  - prescaler = 0, digit index = 0, pending = 0, load_ready = 0;
  - active frame: blank = all ones, digits = 0, dp = 0;
  - frame_done = 0;
  - an, seg and dp all driven inactive (all ones when ACTIVE_LOW=1).
- load_ready is registered: load_ready = ~pending, beginning the first cycle after reset deasserts.
- Prescaler: free-running DIVIDE_BY-bit up-counter that wraps naturally.
  - tick = 1 when the prescaler is all ones.
  - On tick the index advances; it wraps from NUM_DIGITS-1 to 0.
- Frame wrap is defined as tick while index == NUM_DIGITS-1. On the wrap cycle:
  - frame_done = 1 on the next cycle, for exactly one cycle;
  - if pending, the shadow frame is copied to the active frame and pending is cleared.
- Load handshake:
  - Transfer occurs when load_valid && load_ready at a clk edge.
  - The transfer captures digits_in, blank_in and dp_in into the shadow registers and sets pending = 1.
  - load_ready falls on the following cycle.
  - load_valid without load_ready is ignored; the producer must hold its data until ready.
- Simultaneous transfer and frame wrap:
  - pending was 0 on that edge, so no swap happens; the new frame becomes pending.
  - The new frame swaps at the next wrap, with worst-case latency of NUM_DIGITS*2^DIVIDE_BY cycles.
- Brightness: let top = prescaler[DIVIDE_BY-1 : DIVIDE_BY-BRIGHT_W].
  - Digit is lit iff top < brightness, or brightness is all ones (always lit).
  - brightness = 0 means dark.
  - Brightness is sampled live, not buffered.
- Output stage (registered, one-cycle latency from index and prescaler):
  - The an bit for the current index is active iff the digit is lit and its active blank bit is 0. All other an bits are inactive.
  - seg = hex decode of the active nibble for the current index; dp = the active dp bit.
  - When the digit is not lit, seg and dp are driven inactive.
  - With ACTIVE_LOW=0, all three outputs are inverted relative to the ACTIVE_LOW=1 patterns.
- Hex decode patterns (active-low, bit order g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Reset mid-frame or mid-handshake: any pending shadow frame is discarded; the display goes dark until the first load is swapped in.

Test Plan (DIVIDE_BY=4, BRIGHT_W=2, NUM_DIGITS=4, ACTIVE_LOW=1, brightness=3):
- Hold reset low 3 cycles, then release → an=1111, seg=1111111, dp=1, load_ready=0 during reset. load_ready=1 on the first cycle after release. Display stays dark for a full frame (64 cycles).
- Load digits_in=16'h1A2F, blank=0, dp=4'b0100 with load_valid held one cycle → load_ready=0 next cycle. No an activity before the first frame_done. After the wrap: slot 0 shows an=1110, seg=0001110; slot 1 shows an=1101, seg=0100100; slot 2 shows an=1011, seg=0001000, dp=0; slot 3 shows an=0111, seg=1111001. load_ready returns to 1 on the wrap.
- Assert load_valid on the exact wrap cycle with pending=0 → frame accepted, but the active frame is unchanged until the following wrap (64 cycles later).
- Hold load_valid while load_ready=0 with different data → data is not captured; the first-accepted shadow frame is the one displayed.
- blank=4'b0010 → an[1] never asserts during slot 1, and seg stays inactive for that slot. Other digits are unaffected.
- brightness=1 → within each 16-cycle slot, an is active for exactly 4 cycles (top==0). With brightness=0, an=1111 at all times.
